// File: rtl/owr_slave_xfer.sv
`timescale 1ns/1ps
// 1-Wire slave transaction engine: reset/presence, command byte, then NBYTES data bytes in or out.
// Latency: bus input sees a 2-clk synchroniser; all slot timing is referenced to the synchronised edge.
// Backpressure: none; the bus master owns timing, and the host buffer is sampled once at command completion.
module owr_slave_xfer #(
    parameter int          NBYTES    = 4,
    parameter int          CLK_DIV_N = 50,
    parameter int          CLK_DIV_O = 10,
    parameter logic [7:0]  READ_CMD  = 8'hBE,
    parameter int          T_RSTL_N  = 400,
    parameter int          T_PDH_N   = 30,
    parameter int          T_PDL_N   = 120,
    parameter int          T_SMP_N   = 30,
    parameter int          T_HLD0_N  = 45,
    parameter int          T_RSTL_O  = 240,
    parameter int          T_PDH_O   = 10,
    parameter int          T_PDL_O   = 40,
    parameter int          T_SMP_O   = 10,
    parameter int          T_HLD0_O  = 20
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ovd_i,
    input  logic [8*NBYTES-1:0]       tx_data_i,
    input  logic                      tx_valid_i,
    output logic [7:0]                cmd_o,
    output logic                      cmd_valid_o,
    output logic [7:0]                rx_data_o,
    output logic [$clog2(NBYTES):0]   rx_idx_o,
    output logic                      rx_valid_o,
    output logic                      done_o,
    output logic                      presence_seen_o,
    inout  wire                       onewire_io
);

    localparam int BW = $clog2(NBYTES) + 1;
    localparam int TW = 16;
    localparam int DW = 16;
    localparam int LW = 24;

    typedef enum logic [2:0] {
        S_IDLE, S_RST_LOW, S_PD_WAIT, S_PD_LOW, S_CMD, S_DATA, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                owr_meta_q, owr_s_q, owr_s_d_q;
    logic [DW-1:0]       div_q, div_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [LW-1:0]       lo_q, lo_d;
    logic                ovd_q, ovd_d;
    logic                owr_oe_q, owr_oe_d;
    logic                slot_act_q, slot_act_d;
    logic [7:0]          sr_q, sr_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [BW-1:0]       byte_cnt_q, byte_cnt_d;
    logic                tx_mode_q, tx_mode_d;
    logic [8*NBYTES-1:0] tx_buf_q, tx_buf_d;
    logic [7:0]          cmd_q, cmd_d;
    logic                cmd_vld_q, cmd_vld_d;
    logic [7:0]          rx_data_q, rx_data_d;
    logic [BW-1:0]       rx_idx_q, rx_idx_d;
    logic                rx_vld_q, rx_vld_d;
    logic                done_q, done_d;
    logic                pres_q, pres_d;

    logic                fall, rise, fall_ok, rst_det;
    logic [DW-1:0]       div_max;
    logic [TW-1:0]       t_pdh, t_pdl, t_smp, t_hld0;
    logic [LW-1:0]       rst_thr;
    logic [7:0]          shifted;

    // Open-drain driver: only ever pulls low.
    assign onewire_io = owr_oe_q ? 1'b0 : 1'bz;

    assign fall    = owr_s_d_q & ~owr_s_q;
    assign rise    = ~owr_s_d_q & owr_s_q;
    // Falls during the presence phase (including our own pull-down) must not disturb its timer.
    assign fall_ok = fall & (state_q != S_PD_WAIT) & (state_q != S_PD_LOW);

    // Slot timing follows the speed latched at reset; the reset threshold follows the live ovd
    // input so a master can enter overdrive with an overdrive-length reset pulse.
    assign div_max = ovd_q ? DW'(CLK_DIV_O - 1) : DW'(CLK_DIV_N - 1);
    assign t_pdh   = ovd_q ? TW'(T_PDH_O)  : TW'(T_PDH_N);
    assign t_pdl   = ovd_q ? TW'(T_PDL_O)  : TW'(T_PDL_N);
    assign t_smp   = ovd_q ? TW'(T_SMP_O)  : TW'(T_SMP_N);
    assign t_hld0  = ovd_q ? TW'(T_HLD0_O) : TW'(T_HLD0_N);
    assign rst_thr = ovd_i ? LW'(T_RSTL_O * CLK_DIV_O) : LW'(T_RSTL_N * CLK_DIV_N);
    // Low time is measured in raw clocks so it is independent of the currently latched speed.
    assign rst_det = ~owr_oe_q & ~owr_s_q & (lo_q >= rst_thr);
    assign shifted = {owr_s_q, sr_q[7:1]};

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owr_meta_q <= 1'b1;
            owr_s_q    <= 1'b1;
            owr_s_d_q  <= 1'b1;
        end else begin
            owr_meta_q <= onewire_io;
            owr_s_q    <= owr_meta_q;
            owr_s_d_q  <= owr_s_q;
        end
    end

    // Next-state logic: tick timer, presence sequencing, bit/byte engine, reset override last.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tcnt_d     = tcnt_q;
        ovd_d      = ovd_q;
        owr_oe_d   = owr_oe_q;
        slot_act_d = slot_act_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        tx_mode_d  = tx_mode_q;
        tx_buf_d   = tx_buf_q;
        cmd_d      = cmd_q;
        cmd_vld_d  = 1'b0;
        rx_data_d  = rx_data_q;
        rx_idx_d   = rx_idx_q;
        rx_vld_d   = 1'b0;
        done_d     = 1'b0;
        pres_d     = pres_q;

        if (owr_s_q || owr_oe_q) begin
            lo_d = '0;
        end else if (lo_q != {LW{1'b1}}) begin
            lo_d = lo_q + LW'(1);
        end else begin
            lo_d = lo_q;
        end

        if (div_q >= div_max) begin
            div_d = '0;
            if (tcnt_q != {TW{1'b1}}) begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end else begin
            div_d = div_q + DW'(1);
        end
        if (fall_ok) begin
            div_d  = '0;
            tcnt_d = '0;
        end

        case (state_q)
            S_RST_LOW: begin
                if (rise) begin
                    state_d = S_PD_WAIT;
                    div_d   = '0;
                    tcnt_d  = '0;
                end
            end
            S_PD_WAIT: begin
                if (tcnt_q == t_pdh) begin
                    state_d  = S_PD_LOW;
                    owr_oe_d = 1'b1;
                    div_d    = '0;
                    tcnt_d   = '0;
                end
            end
            S_PD_LOW: begin
                if (tcnt_q == t_pdl) begin
                    state_d    = S_CMD;
                    owr_oe_d   = 1'b0;
                    pres_d     = 1'b1;
                    slot_act_d = 1'b0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                end
            end
            S_CMD: begin
                if (fall_ok) begin
                    slot_act_d = 1'b1;
                end else if (slot_act_q && tcnt_q == t_smp) begin
                    slot_act_d = 1'b0;
                    sr_d       = shifted;
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        cmd_d      = shifted;
                        cmd_vld_d  = 1'b1;
                        tx_mode_d  = (shifted == READ_CMD);
                        // Without valid host data the slave answers all-ones, i.e. never drives.
                        tx_buf_d   = (shifted == READ_CMD && tx_valid_i) ? tx_data_i : '1;
                        byte_cnt_d = '0;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (byte_cnt_q == BW'(NBYTES)) begin
                    // One clk after the last byte's pulse, so done never overlaps rx_valid.
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (tx_mode_q) begin
                    if (fall_ok) begin
                        slot_act_d = 1'b1;
                        owr_oe_d   = ~tx_buf_q[0];
                    end else if (slot_act_q && tcnt_q == t_hld0) begin
                        slot_act_d = 1'b0;
                        owr_oe_d   = 1'b0;
                        tx_buf_d   = tx_buf_q >> 1;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = byte_cnt_q + BW'(1);
                        end
                    end
                end else begin
                    if (fall_ok) begin
                        slot_act_d = 1'b1;
                    end else if (slot_act_q && tcnt_q == t_smp) begin
                        slot_act_d = 1'b0;
                        sr_d       = shifted;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = shifted;
                            rx_idx_d   = byte_cnt_q;
                            rx_vld_d   = 1'b1;
                            byte_cnt_d = byte_cnt_q + BW'(1);
                        end
                    end
                end
            end
            default: ;
        endcase

        // A long low aborts whatever is in flight; partial bytes are dropped silently.
        if (rst_det) begin
            state_d    = S_RST_LOW;
            ovd_d      = ovd_i;
            owr_oe_d   = 1'b0;
            slot_act_d = 1'b0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            pres_d     = 1'b0;
            cmd_vld_d  = 1'b0;
            rx_vld_d   = 1'b0;
            done_d     = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            tcnt_q     <= '0;
            lo_q       <= '0;
            ovd_q      <= 1'b0;
            owr_oe_q   <= 1'b0;
            slot_act_q <= 1'b0;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            tx_mode_q  <= 1'b0;
            tx_buf_q   <= '0;
            cmd_q      <= '0;
            cmd_vld_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_idx_q   <= '0;
            rx_vld_q   <= 1'b0;
            done_q     <= 1'b0;
            pres_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tcnt_q     <= tcnt_d;
            lo_q       <= lo_d;
            ovd_q      <= ovd_d;
            owr_oe_q   <= owr_oe_d;
            slot_act_q <= slot_act_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            tx_mode_q  <= tx_mode_d;
            tx_buf_q   <= tx_buf_d;
            cmd_q      <= cmd_d;
            cmd_vld_q  <= cmd_vld_d;
            rx_data_q  <= rx_data_d;
            rx_idx_q   <= rx_idx_d;
            rx_vld_q   <= rx_vld_d;
            done_q     <= done_d;
            pres_q     <= pres_d;
        end
    end

    assign cmd_o           = cmd_q;
    assign cmd_valid_o     = cmd_vld_q;
    assign rx_data_o       = rx_data_q;
    assign rx_idx_o        = rx_idx_q;
    assign rx_valid_o      = rx_vld_q;
    assign done_o          = done_q;
    assign presence_seen_o = pres_q;

endmodule
